// File: rtl/fastram_dram_ctrl_if.sv
// fastram_dram_ctrl_if: 68020 CPU bus plus SIMM control lines seen by the fast-RAM controller
interface fastram_dram_ctrl_if #(parameter int BANKS = 2);
    logic             as20;
    logic             ds20;
    logic             rw20;
    logic [1:0]       siz;
    logic [23:0]      a;
    logic [3:0]       d_in;
    logic [3:0]       d_out;
    logic             d_oe;
    logic [1:0]       dsack;
    logic             cfgin_n;
    logic             cfgout_n;
    logic [BANKS-1:0] ras;
    logic [3:0]       cas;
    logic             ram_mux;
    logic             ramoe;
    modport master (
        output as20, ds20, rw20, siz, a, d_in, cfgin_n,
        input  d_out, d_oe, dsack, cfgout_n, ras, cas, ram_mux, ramoe
    );
    modport slave (
        input  as20, ds20, rw20, siz, a, d_in, cfgin_n,
        output d_out, d_oe, dsack, cfgout_n, ras, cas, ram_mux, ramoe
    );
endinterface

// File: rtl/fastram_dram_ctrl.sv
// fastram_dram_ctrl: Zorro-II autoconfig fast-RAM board driving multi-bank FPM DRAM with CBR refresh
module fastram_dram_ctrl #(
    parameter int          BANKS          = 2,
    parameter int          BANK_ADDR_BITS = 21,
    parameter int          CAS_CYCLES     = 2,
    parameter int          REFRESH_DIV    = 218,
    parameter int          REF_RAS_CYCLES = 2,
    parameter logic [15:0] MANUF          = 16'h07DB,
    parameter logic [7:0]  PRODUCT        = 8'h01
) (
    input logic                i_clk,
    input logic                i_rst,
    fastram_dram_ctrl_if.slave io_bus
);
    localparam int TOT_BITS = BANK_ADDR_BITS + $clog2(BANKS);
    localparam int BW = BANKS > 1 ? $clog2(BANKS) : 1;
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [2:0] SIZE_CODE = TOT_BITS == 20 ? 3'b101 : TOT_BITS == 21 ? 3'b110 :
                                       TOT_BITS == 22 ? 3'b111 : 3'b000;
    typedef enum logic [2:0] {IDLE, ROW, COL, CASW, TERM, PRE, RCAS, RRAS} state_t;
    state_t          r_state, w_next;
    logic [3:0]      r_cnt;
    logic [CW-1:0]   r_ref_cnt;
    logic            r_pend, r_cfg, r_shut, r_cfg_ack, r_rd;
    logic [7:0]      r_base;
    logic [BW-1:0]   r_bank, w_bank;
    logic [3:0]      r_lanes, w_lanes, w_nib;
    logic [23:0]     w_off;
    logic [2:0]      w_n;
    logic            w_hit, w_cfg_sel, w_tick, w_start, w_cnt_done, w_cfg_wr;
    // Offset decode: for an aligned base this equals the upper-bit compare, and it tolerates unaligned bases
    assign w_off      = io_bus.a - {r_base, 16'h0000};
    assign w_hit      = r_cfg && (w_off >> TOT_BITS) == 24'd0;
    assign w_bank     = BW'(w_off >> BANK_ADDR_BITS);
    assign w_cfg_sel  = !r_cfg && !r_shut && !io_bus.cfgin_n && io_bus.a[23:16] == 8'hE8;
    assign w_cfg_wr   = w_cfg_sel && !io_bus.as20 && !io_bus.ds20 && !io_bus.rw20;
    assign w_tick     = r_ref_cnt == CW'(REFRESH_DIV - 1);
    assign w_start    = !io_bus.as20 && w_hit && (io_bus.rw20 || !io_bus.ds20);
    assign w_n        = io_bus.siz == 2'b00 ? 3'd4 : {1'b0, io_bus.siz};
    assign w_cnt_done = r_cnt == (r_state == CASW ? 4'(CAS_CYCLES - 1) : 4'(REF_RAS_CYCLES - 1));
    always_comb begin
        for (int k = 0; k < 4; k++)
            w_lanes[3 - k] = io_bus.rw20 || (k >= int'(io_bus.a[1:0]) && k < int'(io_bus.a[1:0]) + int'(w_n));
    end
    always_comb begin
        case (io_bus.a[7:0])
            8'h00:   w_nib = 4'b1110;
            8'h02:   w_nib = {1'b0, SIZE_CODE};
            8'h04:   w_nib = ~PRODUCT[7:4];
            8'h06:   w_nib = ~PRODUCT[3:0];
            8'h10:   w_nib = ~MANUF[15:12];
            8'h12:   w_nib = ~MANUF[11:8];
            8'h14:   w_nib = ~MANUF[7:4];
            8'h16:   w_nib = ~MANUF[3:0];
            default: w_nib = 4'hF;
        endcase
    end
    // A pending or same-edge refresh tick wins over a CPU start, which then waits with AS20 low
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (r_pend || w_tick) ? RCAS : w_start ? ROW : IDLE;
            ROW:     w_next = io_bus.as20 ? PRE : COL;
            COL:     w_next = io_bus.as20 ? PRE : CASW;
            CASW:    w_next = io_bus.as20 ? PRE : w_cnt_done ? TERM : CASW;
            TERM:    w_next = io_bus.as20 ? PRE : TERM;
            RCAS:    w_next = RRAS;
            RRAS:    w_next = w_cnt_done ? PRE : RRAS;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_ref_cnt <= '0;
            r_pend    <= 1'b0;
            r_cfg     <= 1'b0;
            r_shut    <= 1'b0;
            r_cfg_ack <= 1'b0;
            r_base    <= '0;
            r_bank    <= '0;
            r_lanes   <= '0;
            r_rd      <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= w_next != r_state ? 4'd0 : r_cnt + 4'd1;
            r_ref_cnt <= w_tick ? '0 : r_ref_cnt + CW'(1);
            r_pend    <= (r_state == RRAS && w_cnt_done) ? 1'b0 : r_pend || w_tick;
            r_cfg_ack <= !io_bus.as20 && (r_cfg_ack || w_cfg_sel);
            if (w_cfg_wr && io_bus.a[7:0] == 8'h4A)
                r_base[3:0] <= io_bus.d_in;
            if (w_cfg_wr && io_bus.a[7:0] == 8'h48) begin
                r_base[7:4] <= io_bus.d_in;
                r_cfg       <= 1'b1;
            end
            if (w_cfg_wr && io_bus.a[7:0] == 8'h4C)
                r_shut <= 1'b1;
            if (r_state == IDLE) begin
                r_bank  <= w_bank;
                r_lanes <= w_lanes;
                r_rd    <= io_bus.rw20;
            end
        end
    end
    assign io_bus.ras      = r_state inside {ROW, COL, CASW, TERM} ? ~(BANKS'(1) << r_bank) :
                             r_state == RRAS ? '0 : '1;
    assign io_bus.cas      = r_state inside {CASW, TERM} ? ~r_lanes : r_state inside {RCAS, RRAS} ? 4'h0 : 4'hF;
    assign io_bus.ram_mux  = r_state inside {COL, CASW, TERM};
    assign io_bus.ramoe    = !(r_rd && r_state inside {CASW, TERM});
    assign io_bus.dsack    = (r_cfg_ack || r_state == TERM || (r_state == CASW && w_cnt_done)) ? 2'b00 : 2'b11;
    assign io_bus.d_oe     = r_cfg_ack && io_bus.rw20;
    assign io_bus.d_out    = w_nib;
    assign io_bus.cfgout_n = !(r_cfg || r_shut);
endmodule
